irq_controller: RTL and testbench

Interrupt controller and arbiter sitting in front of the pipelined CPU's single `irq` input. It collects up to 8 external interrupt sources and latches them as pending, with per-source mask and edge/level mode. It selects one fixed-priority winner, holds a request to the CPU until the CPU acknowledges entry into the handler, and blocks further requests until the handler signals end-of-interrupt.

---
 rtl/irq_controller_pkg.sv | 17 +
 rtl/irq_priority_enc.sv | 26 ++
 rtl/irq_controller.sv | 110 +++++++++++
 tb/tb_irq_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller: FSM encodings, config
// register addresses and default sizing.
package irq_controller_pkg;

  localparam int N_DEFAULT   = 8;
  localparam int IDW_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic CFG_MASK = 1'b0;
  localparam logic CFG_MODE = 1'b1;

endpackage

// File: rtl/irq_priority_enc.sv
// Combinational lowest-index-wins priority encoder with a valid flag.
module irq_priority_enc
  import irq_controller_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = IDW_DEFAULT
) (
  input  logic [N-1:0]   req,
  output logic [IDW-1:0] id,
  output logic           valid
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    // Walk from the top down so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = IDW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt collector and fixed-priority arbiter driving the CPU's single irq
// line; one handler in flight at a time, released by an end-of-interrupt pulse.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = IDW_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   src,
  input  logic           ack,
  input  logic           eoi,
  input  logic           cfg_w,
  input  logic           cfg_addr,
  input  logic [N-1:0]   cfg_wd,
  output logic           irq,
  output logic [IDW-1:0] cause,
  output logic           busy,
  output logic [N-1:0]   pending
);

  logic [N-1:0]   mask;
  logic [N-1:0]   mode;
  logic [N-1:0]   prev;
  state_t         state;

  logic [N-1:0]   set_vec;
  logic [N-1:0]   clr_vec;
  logic [N-1:0]   armed;
  logic [IDW-1:0] win_id;
  logic           win_valid;
  logic           ack_take;

  // Level sources set while high; edge sources only on a 0->1 transition.
  assign set_vec  = (mode & src) | (~mode & src & ~prev);
  assign ack_take = (state == REQ) && ack;
  assign clr_vec  = ack_take ? (N'(1) << cause) : '0;
  assign armed    = pending & mask;

  irq_priority_enc #(
    .N   (N),
    .IDW (IDW)
  ) u_enc (
    .req   (armed),
    .id    (win_id),
    .valid (win_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask <= '0;
      mode <= '0;
    end else if (cfg_w) begin
      if (cfg_addr == CFG_MASK) mask <= cfg_wd;
      else                      mode <= cfg_wd;
    end
  end

  // A new set outranks the clear of the granted bit in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev    <= '0;
      pending <= '0;
    end else begin
      prev    <= src;
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cause <= '0;
      irq   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state <= REQ;
            cause <= win_id;
            irq   <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            state <= SERVICE;
            irq   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller: expected output snapshots are queued as
// each stimulus step is applied and popped for comparison after the edge.
module tb_irq_controller;

  typedef struct packed {
    logic [7:0] src;
    logic       ack;
    logic       eoi;
    logic       cfg_w;
    logic       cfg_addr;
    logic [7:0] cfg_wd;
  } stim_t;

  typedef struct packed {
    logic       irq;
    logic       busy;
    logic [2:0] cause;
    logic [7:0] pending;
  } obs_t;

  logic       clock;
  logic       reset;
  logic [7:0] src;
  logic       ack;
  logic       eoi;
  logic       cfg_w;
  logic       cfg_addr;
  logic [7:0] cfg_wd;
  logic       irq;
  logic [2:0] cause;
  logic       busy;
  logic [7:0] pending;

  obs_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  irq_controller #(.N(8), .IDW(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .src      (src),
    .ack      (ack),
    .eoi      (eoi),
    .cfg_w    (cfg_w),
    .cfg_addr (cfg_addr),
    .cfg_wd   (cfg_wd),
    .irq      (irq),
    .cause    (cause),
    .busy     (busy),
    .pending  (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic stim_t sv(input logic [7:0] s, input logic a, input logic e);
    stim_t t;
    t = '{src: s, ack: a, eoi: e, cfg_w: 1'b0, cfg_addr: 1'b0, cfg_wd: 8'h00};
    return t;
  endfunction

  function automatic stim_t cw(input logic addr, input logic [7:0] wd);
    stim_t t;
    t = '{src: 8'h00, ack: 1'b0, eoi: 1'b0, cfg_w: 1'b1, cfg_addr: addr, cfg_wd: wd};
    return t;
  endfunction

  function automatic obs_t ob(input logic i, input logic b, input logic [2:0] c,
                              input logic [7:0] p);
    obs_t o;
    o = '{irq: i, busy: b, cause: c, pending: p};
    return o;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o = '{irq: irq, busy: busy, cause: cause, pending: pending};
    return o;
  endfunction

  // Drive one cycle of stimulus and sample just after the rising edge.
  task automatic apply(input stim_t s);
    src = s.src; ack = s.ack; eoi = s.eoi;
    cfg_w = s.cfg_w; cfg_addr = s.cfg_addr; cfg_wd = s.cfg_wd;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b1;
    src = '0; ack = 1'b0; eoi = 1'b0; cfg_w = 1'b0; cfg_addr = 1'b0; cfg_wd = '0;
    sb.push_back(ob(0, 0, 0, 8'h00));
    repeat (2) @(posedge clock);
    #1;
    e = sb.pop_front(); n_vec++;
    if (observed() !== e) begin
      n_miss++;
      $display("FAIL reset: got irq=%0b busy=%0b cause=%0d pending=%02h, want irq=%0b busy=%0b cause=%0d pending=%02h",
               irq, busy, cause, pending, e.irq, e.busy, e.cause, e.pending);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  e;
    st.push_back(cw(1'b0, 8'hFF));    ex.push_back(ob(0, 0, 0, 8'h00));
    st.push_back(sv(8'h08, 0, 0));    ex.push_back(ob(0, 0, 0, 8'h08));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(1, 0, 3, 8'h08));
    st.push_back(sv(8'h00, 1, 0));    ex.push_back(ob(0, 1, 3, 8'h00));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(0, 1, 3, 8'h00));
    st.push_back(sv(8'h00, 0, 1));    ex.push_back(ob(0, 0, 3, 8'h00));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(0, 0, 3, 8'h00));
    for (int k = 0; k < st.size(); k++) begin
      sb.push_back(ex[k]);
      apply(st[k]);
      e = sb.pop_front(); n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL single[%0d]: got irq=%0b busy=%0b cause=%0d pending=%02h, want irq=%0b busy=%0b cause=%0d pending=%02h",
                 k, irq, busy, cause, pending, e.irq, e.busy, e.cause, e.pending);
      end
    end
  endtask

  task automatic test_priority();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  e;
    st.push_back(sv(8'h24, 0, 0));    ex.push_back(ob(0, 0, 3, 8'h24));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(1, 0, 2, 8'h24));
    st.push_back(sv(8'h00, 1, 0));    ex.push_back(ob(0, 1, 2, 8'h20));
    st.push_back(sv(8'h00, 0, 1));    ex.push_back(ob(0, 0, 2, 8'h20));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(1, 0, 5, 8'h20));
    st.push_back(sv(8'h00, 1, 0));    ex.push_back(ob(0, 1, 5, 8'h00));
    st.push_back(sv(8'h00, 0, 1));    ex.push_back(ob(0, 0, 5, 8'h00));
    for (int k = 0; k < st.size(); k++) begin
      sb.push_back(ex[k]);
      apply(st[k]);
      e = sb.pop_front(); n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL priority[%0d]: got irq=%0b busy=%0b cause=%0d pending=%02h, want irq=%0b busy=%0b cause=%0d pending=%02h",
                 k, irq, busy, cause, pending, e.irq, e.busy, e.cause, e.pending);
      end
    end
  endtask

  task automatic test_mask();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  e;
    st.push_back(cw(1'b0, 8'h00));    ex.push_back(ob(0, 0, 5, 8'h00));
    st.push_back(sv(8'h02, 0, 0));    ex.push_back(ob(0, 0, 5, 8'h02));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(0, 0, 5, 8'h02));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(0, 0, 5, 8'h02));
    st.push_back(cw(1'b0, 8'h02));    ex.push_back(ob(0, 0, 5, 8'h02));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(1, 0, 1, 8'h02));
    st.push_back(sv(8'h00, 1, 0));    ex.push_back(ob(0, 1, 1, 8'h00));
    st.push_back(sv(8'h00, 0, 1));    ex.push_back(ob(0, 0, 1, 8'h00));
    for (int k = 0; k < st.size(); k++) begin
      sb.push_back(ex[k]);
      apply(st[k]);
      e = sb.pop_front(); n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL mask[%0d]: got irq=%0b busy=%0b cause=%0d pending=%02h, want irq=%0b busy=%0b cause=%0d pending=%02h",
                 k, irq, busy, cause, pending, e.irq, e.busy, e.cause, e.pending);
      end
    end
  endtask

  task automatic test_no_preempt();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  e;
    st.push_back(cw(1'b0, 8'hFF));    ex.push_back(ob(0, 0, 1, 8'h00));
    st.push_back(sv(8'h10, 0, 0));    ex.push_back(ob(0, 0, 1, 8'h10));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(1, 0, 4, 8'h10));
    st.push_back(sv(8'h01, 0, 0));    ex.push_back(ob(1, 0, 4, 8'h11));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(1, 0, 4, 8'h11));
    st.push_back(cw(1'b0, 8'h00));    ex.push_back(ob(1, 0, 4, 8'h11));
    st.push_back(cw(1'b0, 8'hFF));    ex.push_back(ob(1, 0, 4, 8'h11));
    st.push_back(sv(8'h00, 1, 0));    ex.push_back(ob(0, 1, 4, 8'h01));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(0, 1, 4, 8'h01));
    st.push_back(sv(8'h00, 0, 1));    ex.push_back(ob(0, 0, 4, 8'h01));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(1, 0, 0, 8'h01));
    st.push_back(sv(8'h00, 1, 0));    ex.push_back(ob(0, 1, 0, 8'h00));
    st.push_back(sv(8'h00, 0, 1));    ex.push_back(ob(0, 0, 0, 8'h00));
    for (int k = 0; k < st.size(); k++) begin
      sb.push_back(ex[k]);
      apply(st[k]);
      e = sb.pop_front(); n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL no_preempt[%0d]: got irq=%0b busy=%0b cause=%0d pending=%02h, want irq=%0b busy=%0b cause=%0d pending=%02h",
                 k, irq, busy, cause, pending, e.irq, e.busy, e.cause, e.pending);
      end
    end
  endtask

  task automatic test_level();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  e;
    st.push_back(cw(1'b1, 8'h40));    ex.push_back(ob(0, 0, 0, 8'h00));
    st.push_back(sv(8'h40, 0, 0));    ex.push_back(ob(0, 0, 0, 8'h40));
    st.push_back(sv(8'h40, 0, 0));    ex.push_back(ob(1, 0, 6, 8'h40));
    st.push_back(sv(8'h40, 1, 0));    ex.push_back(ob(0, 1, 6, 8'h40));
    st.push_back(sv(8'h40, 0, 0));    ex.push_back(ob(0, 1, 6, 8'h40));
    st.push_back(sv(8'h40, 1, 1));    ex.push_back(ob(0, 0, 6, 8'h40));
    st.push_back(sv(8'h40, 0, 0));    ex.push_back(ob(1, 0, 6, 8'h40));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(1, 0, 6, 8'h40));
    st.push_back(sv(8'h00, 1, 0));    ex.push_back(ob(0, 1, 6, 8'h00));
    st.push_back(sv(8'h00, 0, 1));    ex.push_back(ob(0, 0, 6, 8'h00));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(0, 0, 6, 8'h00));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(0, 0, 6, 8'h00));
    st.push_back(cw(1'b1, 8'h00));    ex.push_back(ob(0, 0, 6, 8'h00));
    for (int k = 0; k < st.size(); k++) begin
      sb.push_back(ex[k]);
      apply(st[k]);
      e = sb.pop_front(); n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL level[%0d]: got irq=%0b busy=%0b cause=%0d pending=%02h, want irq=%0b busy=%0b cause=%0d pending=%02h",
                 k, irq, busy, cause, pending, e.irq, e.busy, e.cause, e.pending);
      end
    end
  endtask

  task automatic test_stray_and_reset();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  e;
    st.push_back(sv(8'h00, 1, 0));    ex.push_back(ob(0, 0, 6, 8'h00));
    st.push_back(sv(8'h00, 0, 1));    ex.push_back(ob(0, 0, 6, 8'h00));
    st.push_back(sv(8'h01, 0, 0));    ex.push_back(ob(0, 0, 6, 8'h01));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(1, 0, 0, 8'h01));
    st.push_back(sv(8'h00, 0, 1));    ex.push_back(ob(1, 0, 0, 8'h01));
    st.push_back(sv(8'h00, 1, 1));    ex.push_back(ob(0, 1, 0, 8'h00));
    st.push_back(sv(8'h04, 1, 0));    ex.push_back(ob(0, 1, 0, 8'h04));
    for (int k = 0; k < st.size(); k++) begin
      sb.push_back(ex[k]);
      apply(st[k]);
      e = sb.pop_front(); n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL stray[%0d]: got irq=%0b busy=%0b cause=%0d pending=%02h, want irq=%0b busy=%0b cause=%0d pending=%02h",
                 k, irq, busy, cause, pending, e.irq, e.busy, e.cause, e.pending);
      end
    end

    // Mid-cycle reset during SERVICE must clear outputs before any clock edge.
    src = 8'h00; ack = 1'b0; eoi = 1'b0;
    #2;
    reset = 1'b1;
    sb.push_back(ob(0, 0, 0, 8'h00));
    #1;
    e = sb.pop_front(); n_vec++;
    if (observed() !== e) begin
      n_miss++;
      $display("FAIL async_reset: got irq=%0b busy=%0b cause=%0d pending=%02h, want irq=%0b busy=%0b cause=%0d pending=%02h",
               irq, busy, cause, pending, e.irq, e.busy, e.cause, e.pending);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Mask came back as zero, so re-enable everything: nothing may be pending.
    st.delete();
    ex.delete();
    st.push_back(cw(1'b0, 8'hFF));    ex.push_back(ob(0, 0, 0, 8'h00));
    st.push_back(sv(8'h00, 0, 0));    ex.push_back(ob(0, 0, 0, 8'h00));
    st.push_back(sv(8'h00, 1, 0));    ex.push_back(ob(0, 0, 0, 8'h00));
    for (int k = 0; k < st.size(); k++) begin
      sb.push_back(ex[k]);
      apply(st[k]);
      e = sb.pop_front(); n_vec++;
      if (observed() !== e) begin
        n_miss++;
        $display("FAIL post_reset[%0d]: got irq=%0b busy=%0b cause=%0d pending=%02h, want irq=%0b busy=%0b cause=%0d pending=%02h",
                 k, irq, busy, cause, pending, e.irq, e.busy, e.cause, e.pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_no_preempt();
    test_level();
    test_stray_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
